// File: rtl/fft_pkg.sv
// Shared constants, index types and FSM states for the radix-2 DIT FFT address sequencer.
// The GAP state exists only when STAGE_GAP_EN is defined.
package fft_pkg;

  localparam int N          = 32;
  localparam int R          = 5;
  localparam int GAP_CYCLES = 4;
  localparam int STG_W      = $clog2(R);
  localparam int HALF_OPS   = N / 2;

  typedef logic [STG_W-1:0] stage_t;
  typedef logic [R-2:0]     bfly_t;
  typedef logic [R-1:0]     addr_t;
  typedef logic [R-2:0]     exp_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN
`ifdef STAGE_GAP_EN
    , ST_GAP
`endif
  } state_t;

endpackage

// File: rtl/fft_addr_gen_if.sv
// Operation bus between the FFT address sequencer (master) and the butterfly datapath (slave).
interface fft_addr_gen_if #(
  parameter int R = fft_pkg::R
);

  localparam int STG_W = $clog2(R);

  logic             i_start;
  logic             i_ready;
  logic             o_valid;
  logic [R-1:0]     o_addr_a;
  logic [R-1:0]     o_addr_b;
  logic [R-2:0]     o_twiddle_exponent;
  logic [STG_W-1:0] o_stage;
  logic             o_last;
  logic             o_busy;
  logic             o_done;

  modport master (
    input  i_start, i_ready,
    output o_valid, o_addr_a, o_addr_b, o_twiddle_exponent,
           o_stage, o_last, o_busy, o_done
  );

  modport slave (
    output i_start, i_ready,
    input  o_valid, o_addr_a, o_addr_b, o_twiddle_exponent,
           o_stage, o_last, o_busy, o_done
  );

endinterface

// File: rtl/fft_addr_map.sv
// Combinational map from (stage s, butterfly j) to the in-place data addresses and twiddle exponent.
module fft_addr_map #(
  parameter int R = fft_pkg::R
) (
  input  logic [$clog2(R)-1:0] s,
  input  logic [R-2:0]         j,
  output logic [R-1:0]         addr_a,
  output logic [R-1:0]         addr_b,
  output logic [R-2:0]         k
);

  localparam int BW = R - 1;

  logic [BW-1:0] mask;
  logic [BW-1:0] pos;
  logic [BW-1:0] grp;

  // At s = R-1 the mask shift wraps to zero, so the subtraction yields all ones.
  always_comb begin
    mask   = (BW'(1) << s) - BW'(1);
    pos    = j & mask;
    grp    = j >> s;
    addr_a = ({1'b0, grp} << (s + 1'b1)) | {1'b0, pos};
    addr_b = addr_a + (R'(1) << s);
    k      = pos << (BW - int'(s));
  end

endmodule

// File: rtl/fft_addr_gen.sv
// Radix-2 DIT FFT sequencer: emits R stages of N/2 butterflies (addresses + twiddle exponent).
// Define STAGE_GAP_EN to insert GAP idle cycles between stages for RAM read-after-write latency.
module fft_addr_gen
  import fft_pkg::*;
#(
  parameter int N = fft_pkg::N,
  parameter int R = fft_pkg::R
`ifdef STAGE_GAP_EN
  , parameter int GAP = fft_pkg::GAP_CYCLES
`endif
) (
  input  logic           i_clk,
  input  logic           i_rst,
  fft_addr_gen_if.master bus
);

  localparam int SW = $clog2(R);
  localparam int BW = R - 1;

  localparam logic [SW-1:0] S_LAST = SW'(R - 1);
  localparam logic [BW-1:0] J_LAST = BW'(N / 2 - 1);

  state_t          state, state_nxt;
  logic [SW-1:0]   s, s_nxt;
  logic [BW-1:0]   j, j_nxt;
  logic            valid_q, valid_nxt;
  logic            busy_q, busy_nxt;
  logic            done_q, done_nxt;
  logic            last_q, last_nxt;
  logic [R-1:0]    addr_a_q, addr_a_nxt;
  logic [R-1:0]    addr_b_q, addr_b_nxt;
  logic [BW-1:0]   k_q, k_nxt;
  logic            fire;

`ifdef STAGE_GAP_EN
  localparam int GAP_W = (GAP < 1) ? 1 : $clog2(GAP + 1);
  logic [GAP_W-1:0] gap_cnt, gap_cnt_nxt;
`endif

  assign fire = valid_q & bus.i_ready;

  // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latches).
  always_comb begin
    state_nxt = state;
    s_nxt     = s;
    j_nxt     = j;
    valid_nxt = valid_q;
    busy_nxt  = busy_q;
    done_nxt  = 1'b0;
`ifdef STAGE_GAP_EN
    gap_cnt_nxt = gap_cnt;
`endif

    unique case (state)
      ST_IDLE: begin
        if (bus.i_start) begin
          state_nxt = ST_RUN;
          s_nxt     = '0;
          j_nxt     = '0;
          valid_nxt = 1'b1;
          busy_nxt  = 1'b1;
        end
      end

      ST_RUN: begin
        if (fire) begin
          if (j != J_LAST) begin
            j_nxt = j + 1'b1;
          end else if (s == S_LAST) begin
            state_nxt = ST_IDLE;
            s_nxt     = '0;
            j_nxt     = '0;
            valid_nxt = 1'b0;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
          end else begin
            s_nxt = s + 1'b1;
            j_nxt = '0;
`ifdef STAGE_GAP_EN
            // The next stage's first operation is staged during the gap but held invalid.
            state_nxt   = ST_GAP;
            valid_nxt   = 1'b0;
            gap_cnt_nxt = GAP_W'(GAP - 1);
`endif
          end
        end
      end

`ifdef STAGE_GAP_EN
      ST_GAP: begin
        if (gap_cnt == '0) begin
          state_nxt = ST_RUN;
          valid_nxt = 1'b1;
        end else begin
          gap_cnt_nxt = gap_cnt - 1'b1;
        end
      end
`endif

      default: state_nxt = ST_IDLE;
    endcase

    last_nxt = valid_nxt && (s_nxt == S_LAST) && (j_nxt == J_LAST);
  end

  // Mapping is applied to the next (s, j) so the registered outputs track the counters with no extra latency.
  fft_addr_map #(.R(R)) u_map (
    .s      (s_nxt),
    .j      (j_nxt),
    .addr_a (addr_a_nxt),
    .addr_b (addr_b_nxt),
    .k      (k_nxt)
  );

  // NOTE: i_rst is sampled only on the clock edge, so it stays out of the sensitivity list.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= ST_IDLE;
      s        <= '0;
      j        <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      last_q   <= 1'b0;
      addr_a_q <= '0;
      addr_b_q <= '0;
      k_q      <= '0;
    end else begin
      // NOTE: non-blocking updates keep every register reading the pre-edge values.
      state    <= state_nxt;
      s        <= s_nxt;
      j        <= j_nxt;
      valid_q  <= valid_nxt;
      busy_q   <= busy_nxt;
      done_q   <= done_nxt;
      last_q   <= last_nxt;
      addr_a_q <= addr_a_nxt;
      addr_b_q <= addr_b_nxt;
      k_q      <= k_nxt;
    end
  end

`ifdef STAGE_GAP_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      gap_cnt <= '0;
    end else begin
      gap_cnt <= gap_cnt_nxt;
    end
  end
`endif

  assign bus.o_valid            = valid_q;
  assign bus.o_addr_a           = addr_a_q;
  assign bus.o_addr_b           = addr_b_q;
  assign bus.o_twiddle_exponent = k_q;
  assign bus.o_stage            = s;
  assign bus.o_last             = last_q;
  assign bus.o_busy             = busy_q;
  assign bus.o_done             = done_q;

endmodule

// File: tb/tb_fft_addr_gen.sv
// Scoreboard bench for fft_addr_gen: a driver queues the expected operation list per FFT and a
// negedge monitor compares every presented operation; also honours STAGE_GAP_EN when defined.
module tb_fft_addr_gen;
  import fft_pkg::*;

`ifdef STAGE_GAP_EN
  localparam int GAP_B = GAP_CYCLES;
`else
  localparam int GAP_B = 0;
`endif
  localparam int OPS      = R * HALF_OPS;
  localparam int EXP_DONE = OPS + (R - 1) * GAP_B + 1;
  localparam int BOUND    = 2000;

  typedef struct {
    addr_t  a;
    addr_t  b;
    exp_t   k;
    stage_t s;
    logic   last;
  } op_t;

  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  bit   expect_done = 1'b0;
  op_t  q[$];

  fft_addr_gen_if #(.R(R)) bus ();

  fft_addr_gen dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: addr_a is the j-th address with bit s clear; k scales the in-group offset by N/(2*half).
  task automatic push_fft();
    for (int s = 0; s < R; s++) begin
      for (int j = 0; j < HALF_OPS; j++) begin
        op_t o;
        int  half = 1 << s;
        int  low  = j % half;
        int  high = j / half;
        o.a    = addr_t'(high * 2 * half + low);
        o.b    = addr_t'(high * 2 * half + low + half);
        o.k    = exp_t'(low * (N / (2 * half)));
        o.s    = stage_t'(s);
        o.last = (s == R - 1) && (j == HALF_OPS - 1);
        q.push_back(o);
      end
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_valid"},  32'(bus.o_valid), 0);
    check({tag, "_busy"},   32'(bus.o_busy), 0);
    check({tag, "_done"},   32'(bus.o_done), 0);
    check({tag, "_last"},   32'(bus.o_last), 0);
    check({tag, "_addr_a"}, 32'(bus.o_addr_a), 0);
    check({tag, "_addr_b"}, 32'(bus.o_addr_b), 0);
    check({tag, "_k"},      32'(bus.o_twiddle_exponent), 0);
    check({tag, "_stage"},  32'(bus.o_stage), 0);
  endtask

  task automatic start_fft(input bit immediate);
    if (!immediate) begin
      @(posedge clk);
      #1;
    end
    bus.i_start = 1'b1;
    bus.i_ready = 1'b1;
    push_fft();
    @(posedge clk);
    #1;
    bus.i_start = 1'b0;
    bus.i_ready = 1'b1;
  endtask

  // Counts cycles after start acceptance until o_done; returns at the negedge of the done cycle.
  task automatic wait_done(input bit rand_ready, input bit poke, output int cycles, output int idle);
    bit seen = 1'b0;
    cycles = 0;
    idle   = 0;
    while (!seen && cycles < BOUND) begin
      @(negedge clk);
      cycles++;
      if (bus.o_done) begin
        seen = 1'b1;
      end else begin
        if (bus.o_busy && !bus.o_valid) idle++;
        @(posedge clk);
        #1;
        bus.i_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        bus.i_start = poke && (cycles == 20 || cycles == 21);
      end
    end
    check("done_seen", 32'(bus.o_done), 1);
  endtask

  initial begin
    op_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        expect_done = 1'b0;
      end else begin
        if (expect_done) begin
          check("done_after_last", 32'(bus.o_done), 1);
          check("busy_after_last", 32'(bus.o_busy), 0);
          expect_done = 1'b0;
        end else if (bus.o_done) begin
          check("done_spurious", 32'(bus.o_done), 0);
        end
        if (bus.o_valid) begin
          if (q.size() == 0) begin
            check("op_expected", 32'(q.size()), 1);
          end else begin
            e = q[0];
            check("addr_a", 32'(bus.o_addr_a), 32'(e.a));
            check("addr_b", 32'(bus.o_addr_b), 32'(e.b));
            check("twiddle_k", 32'(bus.o_twiddle_exponent), 32'(e.k));
            check("stage", 32'(bus.o_stage), 32'(e.s));
            check("last", 32'(bus.o_last), 32'(e.last));
            check("busy_while_valid", 32'(bus.o_busy), 1);
            if (bus.i_ready) begin
              void'(q.pop_front());
              if (e.last) expect_done = 1'b1;
            end
          end
        end
      end
    end
  end

  initial begin
    int cycles;
    int idle;
    rst         = 1'b1;
    bus.i_start = 1'b0;
    bus.i_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_idle("reset");

    // Back-to-back handshakes: exact done timing.
    start_fft(1'b0);
    wait_done(1'b0, 1'b0, cycles, idle);
    check("runA_done_cycle", 32'(cycles), EXP_DONE);
    check("runA_gap_idle", 32'(idle), (R - 1) * GAP_B);
    check("runA_ops_left", 32'(q.size()), 0);
    check("runA_valid_at_done", 32'(bus.o_valid), 0);

    // Restart in the done cycle, with start pokes while busy.
    start_fft(1'b1);
    wait_done(1'b0, 1'b1, cycles, idle);
    check("runB_done_cycle", 32'(cycles), EXP_DONE);
    check("runB_ops_left", 32'(q.size()), 0);
    @(negedge clk);
    check("runB_done_width", 32'(bus.o_done), 0);

    // Random backpressure with start pokes.
    start_fft(1'b0);
    wait_done(1'b1, 1'b1, cycles, idle);
    check("runC_ops_left", 32'(q.size()), 0);
    check("runC_gap_idle", 32'(idle), (R - 1) * GAP_B);
    @(negedge clk);
    check("runC_done_width", 32'(bus.o_done), 0);

    // Reset while presenting s=2, j=7.
    start_fft(1'b0);
    repeat (2 * HALF_OPS + 7 + 2 * GAP_B) @(posedge clk);
    #1;
    check("mid_stage", 32'(bus.o_stage), 2);
    check("mid_addr_a", 32'(bus.o_addr_a), 11);
    check("mid_addr_b", 32'(bus.o_addr_b), 15);
    check("mid_k", 32'(bus.o_twiddle_exponent), 12);
    rst         = 1'b1;
    bus.i_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    check_idle("midrst");
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("midrst_no_done", 32'(bus.o_done), 0);
    end

    // Fresh start after reset begins at s=0, j=0.
    start_fft(1'b0);
    wait_done(1'b0, 1'b0, cycles, idle);
    check("runD_done_cycle", 32'(cycles), EXP_DONE);
    check("runD_ops_left", 32'(q.size()), 0);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
